// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; issues loads/stores on a req/ack port, big-endian lanes, drives MEM/WB.
// Latency: non-memops 1 cycle; memops 1 issue cycle plus REQ cycles until ack or timeout (2 cycles minimum).
// Backpressure: combinational Stall_OUT freezes upstream while a memop is pending. Option: MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [5:0] OP_LB  = 6'h20,
  parameter logic [5:0] OP_LH  = 6'h21,
  parameter logic [5:0] OP_LW  = 6'h23,
  parameter logic [5:0] OP_LBU = 6'h24,
  parameter logic [5:0] OP_LHU = 6'h25,
  parameter logic [5:0] OP_SB  = 6'h28,
  parameter logic [5:0] OP_SH  = 6'h29,
  parameter logic [5:0] OP_SW  = 6'h2B
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        DMEM_Req_OUT,
  output logic        DMEM_Write_OUT,
  output logic [31:0] DMEM_Addr_OUT,
  output logic [31:0] DMEM_WData_OUT,
  output logic [3:0]  DMEM_ByteEn_OUT,
  input  logic        DMEM_Ack_IN,
  input  logic [31:0] DMEM_RData_IN,
  output logic        Stall_OUT,
  output logic        Err_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [31:0] Fwd_MEM_WriteData_OUT
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [5:0]  ld_ctl;
  logic [1:0]  ld_off;
  logic        memop;
  logic        in_req;
  logic        timeout_hit;
  logic        done;
  logic        misalign;
  logic [1:0]  off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign memop  = MemRead1_IN | MemWrite1_IN;
  assign off    = ALU_result1_IN[1:0];
  assign in_req = (state == S_REQ);
  // The abort edge is the one on which the wait counter would reach TIMEOUT_CYCLES,
  // so REQ lasts at most TIMEOUT_CYCLES cycles.
  assign timeout_hit = in_req && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  // An ack wins over a coinciding timeout; either way the instruction leaves this cycle.
  assign done = in_req & (DMEM_Ack_IN | timeout_hit);
  // Stall is released in the completing cycle so upstream never reissues the memop.
  assign Stall_OUT = ~RESET & memop & ~misalign & ~done;
  assign Fwd_MEM_WriteData_OUT = WriteData1_OUT;

`ifdef MEM_ALIGN_CHECK_EN
  // Flag misaligned halfword/word accesses at issue time; byte accesses never fault.
  always_comb begin
    misalign = 1'b0;
    if (!in_req && memop) begin
      if (MemWrite1_IN) begin
        if (ALU_Control1_IN == OP_SH)      misalign = off[0];
        else if (ALU_Control1_IN != OP_SB) misalign = |off;
      end else begin
        if (ALU_Control1_IN == OP_LH || ALU_Control1_IN == OP_LHU)       misalign = off[0];
        else if (ALU_Control1_IN != OP_LB && ALU_Control1_IN != OP_LBU)  misalign = |off;
      end
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Store lane replication and byte enables; loads and unknown codes use the full word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = MemWriteData1_IN;
    if (MemWrite1_IN) begin
      if (ALU_Control1_IN == OP_SB) begin
        be_next    = 4'b1000 >> off;
        wdata_next = {4{MemWriteData1_IN[7:0]}};
      end else if (ALU_Control1_IN == OP_SH) begin
        be_next    = off[1] ? 4'b0011 : 4'b1100;
        wdata_next = {2{MemWriteData1_IN[15:0]}};
      end
    end
  end

  // Big-endian load lane extraction from the latched type and byte offset.
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = DMEM_RData_IN[31:24];
      2'd1:    ld_byte = DMEM_RData_IN[23:16];
      2'd2:    ld_byte = DMEM_RData_IN[15:8];
      default: ld_byte = DMEM_RData_IN[7:0];
    endcase
    ld_half = ld_off[1] ? DMEM_RData_IN[15:0] : DMEM_RData_IN[31:16];
    if (ld_ctl == OP_LB)       ld_data = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_ctl == OP_LBU) ld_data = {24'h0, ld_byte};
    else if (ld_ctl == OP_LH)  ld_data = {{16{ld_half[15]}}, ld_half};
    else if (ld_ctl == OP_LHU) ld_data = {16'h0, ld_half};
    else                       ld_data = DMEM_RData_IN;
  end

  // IDLE/REQ control, memory port registers and the MEM/WB pipeline register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state              <= S_IDLE;
      wait_cnt           <= 8'd0;
      ld_ctl             <= 6'd0;
      ld_off             <= 2'd0;
      DMEM_Req_OUT       <= 1'b0;
      DMEM_Write_OUT     <= 1'b0;
      DMEM_Addr_OUT      <= 32'h0;
      DMEM_WData_OUT     <= 32'h0;
      DMEM_ByteEn_OUT    <= 4'h0;
      Err_OUT            <= 1'b0;
      Instr1_OUT         <= 32'h0;
      Instr1_PC_OUT      <= 32'h0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
      WriteData1_OUT     <= 32'h0;
    end else begin
      Err_OUT <= 1'b0;
      if (state == S_IDLE) begin
        if (memop && !misalign) begin
          state           <= S_REQ;
          wait_cnt        <= 8'd0;
          DMEM_Req_OUT    <= 1'b1;
          DMEM_Write_OUT  <= MemWrite1_IN;
          DMEM_Addr_OUT   <= {ALU_result1_IN[31:2], 2'b00};
          DMEM_WData_OUT  <= wdata_next;
          DMEM_ByteEn_OUT <= be_next;
          ld_ctl          <= ALU_Control1_IN;
          ld_off          <= off;
          // bubble to WB while the transaction is outstanding
          Instr1_OUT         <= 32'h0;
          Instr1_PC_OUT      <= 32'h0;
          WriteRegister1_OUT <= 5'd0;
          RegWrite1_OUT      <= 1'b0;
          WriteData1_OUT     <= 32'h0;
        end else begin
          // plain pass-through; a memop reaching here was rejected as misaligned
          Instr1_OUT         <= Instr1_IN;
          Instr1_PC_OUT      <= Instr1_PC_IN;
          WriteRegister1_OUT <= WriteRegister1_IN;
          RegWrite1_OUT      <= RegWrite1_IN & ~memop;
          WriteData1_OUT     <= memop ? 32'h0 : ALU_result1_IN;
          Err_OUT            <= memop;
        end
      end else if (done) begin
        state              <= S_IDLE;
        wait_cnt           <= 8'd0;
        DMEM_Req_OUT       <= 1'b0;
        Instr1_OUT         <= Instr1_IN;
        Instr1_PC_OUT      <= Instr1_PC_IN;
        WriteRegister1_OUT <= WriteRegister1_IN;
        RegWrite1_OUT      <= RegWrite1_IN & ~DMEM_Write_OUT;
        WriteData1_OUT     <= !DMEM_Ack_IN ? 32'h0 : (DMEM_Write_OUT ? ALU_result1_IN : ld_data);
        Err_OUT            <= ~DMEM_Ack_IN;
      end else begin
        wait_cnt           <= wait_cnt + 8'd1;
        Instr1_OUT         <= 32'h0;
        Instr1_PC_OUT      <= 32'h0;
        WriteRegister1_OUT <= 5'd0;
        RegWrite1_OUT      <= 1'b0;
        WriteData1_OUT     <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized instruction stream against a transaction-level model of mem_stage.
// Latency: the bench acts as the upstream stage and holds inputs while the DUT stalls.
// Backpressure: memory ack delays are randomized, including delays past the timeout.
module tb_mem_stage;
  localparam int TO = 4;
  localparam logic [5:0] LD_OPS [6] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h3F};
  localparam logic [5:0] ST_OPS [4] = '{6'h28, 6'h29, 6'h2B, 6'h3E};

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN, DMEM_RData_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, DMEM_Ack_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        DMEM_Req_OUT, DMEM_Write_OUT, Stall_OUT, Err_OUT, RegWrite1_OUT;
  logic [31:0] DMEM_Addr_OUT, DMEM_WData_OUT, Instr1_OUT, Instr1_PC_OUT;
  logic [31:0] WriteData1_OUT, Fwd_MEM_WriteData_OUT;
  logic [3:0]  DMEM_ByteEn_OUT;
  logic [4:0]  WriteRegister1_OUT;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .DMEM_Req_OUT(DMEM_Req_OUT), .DMEM_Write_OUT(DMEM_Write_OUT), .DMEM_Addr_OUT(DMEM_Addr_OUT),
    .DMEM_WData_OUT(DMEM_WData_OUT), .DMEM_ByteEn_OUT(DMEM_ByteEn_OUT),
    .DMEM_Ack_IN(DMEM_Ack_IN), .DMEM_RData_IN(DMEM_RData_IN),
    .Stall_OUT(Stall_OUT), .Err_OUT(Err_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .WriteData1_OUT(WriteData1_OUT), .Fwd_MEM_WriteData_OUT(Fwd_MEM_WriteData_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // expected outputs for the current cycle, maintained by the stimulus process
  logic        chk_en = 1'b0;
  logic        e_req, e_write, e_stall, e_err, e_rw, e_wbval;
  logic [31:0] e_addr, e_wdata, e_instr, e_pc, e_wd;
  logic [3:0]  e_be;
  logic [4:0]  e_wreg;

  // captured during the first REQ cycle of the most recent memop
  int          n_stall;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_req;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("req",   32'(DMEM_Req_OUT),  32'(e_req));
      check("stall", 32'(Stall_OUT),     32'(e_stall));
      check("err",   32'(Err_OUT),       32'(e_err));
      check("rw",    32'(RegWrite1_OUT), 32'(e_rw));
      check("instr", Instr1_OUT,         e_instr);
      check("pc",    Instr1_PC_OUT,      e_pc);
      if (e_wbval) begin
        check("wreg", 32'(WriteRegister1_OUT), 32'(e_wreg));
        check("wd",   WriteData1_OUT,          e_wd);
        check("fwd",  Fwd_MEM_WriteData_OUT,   e_wd);
      end
      if (e_req) begin
        check("dwrite", 32'(DMEM_Write_OUT),  32'(e_write));
        check("daddr",  DMEM_Addr_OUT,        e_addr);
        check("dbe",    32'(DMEM_ByteEn_OUT), 32'(e_be));
        if (e_write) check("dwdata", DMEM_WData_OUT, e_wdata);
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [5:0] ctl, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - int'(off))));
    h = off[1] ? w[15:0] : w[31:16];
    case (ctl)
      6'h20:   return 32'($signed(b));
      6'h24:   return 32'(b);
      6'h21:   return 32'($signed(h));
      6'h25:   return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] ctl, input logic wr, input logic [1:0] off);
`ifdef MEM_ALIGN_CHECK_EN
    logic half, byt;
    half = wr ? (ctl == 6'h29) : (ctl == 6'h21 || ctl == 6'h25);
    byt  = wr ? (ctl == 6'h28) : (ctl == 6'h20 || ctl == 6'h24);
    if (byt)  return 1'b0;
    if (half) return off[0];
    return off != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_reset_expect();
    e_req = 0; e_write = 0; e_stall = 0; e_err = 0; e_rw = 0; e_wbval = 1;
    e_addr = 0; e_wdata = 0; e_instr = 0; e_pc = 0; e_wd = 0; e_be = 0; e_wreg = 0;
  endtask

  // Runs one instruction from issue to completion; called and returns at posedge+1.
  // dly = number of REQ cycles without ack before the ack (>= TO means never acked).
  task automatic issue(input logic [5:0] ctl, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] wdat, input logic [31:0] rdata,
                       input int dly, input logic [4:0] wreg, input logic rwi);
    logic [31:0] instr, pc;
    logic        memop, mis, ack, last;
    logic [1:0]  off;
    instr = $urandom; pc = $urandom; off = alu[1:0];
    Instr1_IN = instr; Instr1_PC_IN = pc; ALU_result1_IN = alu; MemWriteData1_IN = wdat;
    WriteRegister1_IN = wreg; RegWrite1_IN = rwi; ALU_Control1_IN = ctl;
    MemRead1_IN = rd; MemWrite1_IN = wr;
    DMEM_Ack_IN = 1'($urandom_range(0, 1));   // stray acks in IDLE must be ignored
    DMEM_RData_IN = $urandom;
    memop = rd | wr;
    mis = memop && misaligned(ctl, wr, off);
    n_stall = 0; cap_req = 0;
    e_stall = memop && !mis;
    #1 n_stall += int'(Stall_OUT);
    @(posedge CLK); #1;
    if (!memop || mis) begin
      e_req = 0; e_err = mis; e_rw = mis ? 1'b0 : rwi; e_instr = instr; e_pc = pc;
      e_wreg = wreg; e_wd = mis ? 32'h0 : alu; e_wbval = 1;
      return;
    end
    e_req = 1; e_write = wr; e_addr = alu & 32'hFFFF_FFFC; e_err = 0;
    e_rw = 0; e_instr = 0; e_pc = 0; e_wbval = 0;
    if (wr && ctl == 6'h28) begin
      e_be = 4'(8 >> off); e_wdata = 32'(wdat[7:0]) * 32'h0101_0101;
    end else if (wr && ctl == 6'h29) begin
      e_be = off[1] ? 4'd3 : 4'd12; e_wdata = 32'(wdat[15:0]) * 32'h0001_0001;
    end else begin
      e_be = 4'hF; e_wdata = wdat;
    end
    cap_req = DMEM_Req_OUT; cap_addr = DMEM_Addr_OUT; cap_be = DMEM_ByteEn_OUT; cap_wdata = DMEM_WData_OUT;
    ack = 0;
    for (int k = 0; k < TO; k++) begin
      ack = (k == dly);
      DMEM_Ack_IN = ack;
      DMEM_RData_IN = ack ? rdata : $urandom;
      last = ack || (k == TO - 1);
      e_stall = !last;
      #1 n_stall += int'(Stall_OUT);
      @(posedge CLK); #1;
      if (last) break;
    end
    e_req = 0; e_err = !ack; e_rw = wr ? 1'b0 : rwi; e_instr = instr; e_pc = pc; e_wreg = wreg;
    e_wd = !ack ? 32'h0 : (wr ? alu : ld_model(ctl, off, rdata)); e_wbval = 1;
  endtask

  task automatic random_instr();
    int kind;
    logic [5:0] ctl;
    kind = $urandom_range(0, 2);
    ctl = 6'($urandom);
    if (kind == 1) ctl = LD_OPS[$urandom_range(0, 5)];
    if (kind == 2) ctl = ST_OPS[$urandom_range(0, 3)];
    issue(ctl, kind == 1, kind == 2, $urandom, $urandom, $urandom,
          $urandom_range(0, TO + 1), 5'($urandom), 1'($urandom));
  endtask

  initial begin
    RESET = 1; Instr1_IN = 0; Instr1_PC_IN = 0; ALU_result1_IN = 0; MemWriteData1_IN = 0;
    WriteRegister1_IN = 0; RegWrite1_IN = 0; ALU_Control1_IN = 0; MemRead1_IN = 0;
    MemWrite1_IN = 0; DMEM_Ack_IN = 0; DMEM_RData_IN = 0;
    set_reset_expect();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req",   32'(DMEM_Req_OUT),  32'h0);
    check("rst_err",   32'(Err_OUT),       32'h0);
    check("rst_wd",    WriteData1_OUT,     32'h0);
    check("rst_rw",    32'(RegWrite1_OUT), 32'h0);
    RESET = 0;
    chk_en = 1;

    issue(6'h00, 0, 0, 32'h1234, 0, 0, 0, 5'd5, 1);
    check("nonmem_wd",    WriteData1_OUT,          32'h1234);
    check("nonmem_reg",   32'(WriteRegister1_OUT), 32'd5);
    check("nonmem_stall", 32'(n_stall),            32'd0);

    issue(6'h20, 1, 0, 32'h101, 0, 32'h11F0_3344, 3, 5'd7, 1);
    check("lb_addr",  cap_addr,       32'h100);
    check("lb_stall", 32'(n_stall),   32'd4);
    check("lb_data",  WriteData1_OUT, 32'hFFFF_FFF0);
    issue(6'h24, 1, 0, 32'h101, 0, 32'h11F0_3344, 3, 5'd7, 1);
    check("lbu_data", WriteData1_OUT, 32'h0000_00F0);

    issue(6'h29, 0, 1, 32'h202, 32'h0000_ABCD, 0, 0, 5'd9, 1);
    check("sh_be",    32'(cap_be),        32'h3);
    check("sh_wdata", cap_wdata,          32'hABCD_ABCD);
    check("sh_rw",    32'(RegWrite1_OUT), 32'h0);
    check("sh_stall", 32'(n_stall),       32'd1);

    issue(6'h23, 1, 0, 32'h300, 0, 0, 50, 5'd3, 1);
    check("to_err",   32'(Err_OUT),     32'h1);
    check("to_wd",    WriteData1_OUT,   32'h0);
    check("to_stall", 32'(n_stall),     32'd4);

    issue(6'h23, 1, 0, 32'h102, 0, 32'hCAFE_F00D, 1, 5'd4, 1);
`ifdef MEM_ALIGN_CHECK_EN
    check("align_noreq", 32'(cap_req | DMEM_Req_OUT), 32'h0);
    check("align_err",   32'(Err_OUT),       32'h1);
    check("align_rw",    32'(RegWrite1_OUT), 32'h0);
`else
    check("lw_low_bits", cap_addr,       32'h100);
    check("lw_data",     WriteData1_OUT, 32'hCAFE_F00D);
`endif

    for (int i = 0; i < 150; i++) random_instr();

    // asynchronous reset in the middle of a transaction
    chk_en = 0;
    ALU_Control1_IN = 6'h23; ALU_result1_IN = 32'h400; MemRead1_IN = 1; MemWrite1_IN = 0; DMEM_Ack_IN = 0;
    @(posedge CLK); #1;
    check("midreq_req", 32'(DMEM_Req_OUT), 32'h1);
    #2 RESET = 1;
    #1;
    check("async_req",   32'(DMEM_Req_OUT),  32'h0);
    check("async_stall", 32'(Stall_OUT),     32'h0);
    check("async_addr",  DMEM_Addr_OUT,      32'h0);
    check("async_wd",    WriteData1_OUT,     32'h0);
    check("async_err",   32'(Err_OUT),       32'h0);
    @(posedge CLK); #1;
    MemRead1_IN = 0;
    RESET = 0;
    set_reset_expect();
    chk_en = 1;

    for (int i = 0; i < 150; i++) random_instr();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
